cclut_clct_buffer: RTL and testbench
====================================

Name: cclut_clct_buffer

Overview:
- Downstream of the CCLUT pattern lookup stage. Each BX it takes the two LUT results: half-strip key, quarter/eighth-strip subkey, offset and bend.
- Adds the pattern id and hit count, registers the pair and clamps out-of-range keys.
- Suppresses a duplicate second CLCT and tags the pair with the BX number.
- Buffers pairs in a small FIFO that drains to the CLCT/ALCT matching logic under a valid/ready handshake.

Parameters:
MXKEYBX, 8, half-strip key bits
MXXKYB, 10, subkey bits ({key, QS, ES})
MXBNDB, 5, bend bits ([4] L/R sign, [3:0] magnitude)
MXPIDB, 3, pattern id bits
MXHITB, 3, hit-count bits
MXBXNB, 12, BX number bits
MAXKEY, 223, highest legal half-strip key (7 CFEBs x 32 - 1)
FIFO_DEPTH, 8, pair entries (power of 2)

Ports:
clock  in  1  40 MHz system clock
global_reset_n  in  1  synchronous active-low reset
lut_vld  in  1  LUT outputs valid this clock
vld0, vld1  in  1 each  CLCT0/CLCT1 present
subkey0, subkey1  in  MXXKYB each  LUT best_subkey
bend0, bend1  in  MXBNDB each  LUT bend
pid0, pid1  in  MXPIDB each  pattern id (0..4)
nhit0, nhit1  in  MXHITB each  layers hit
bxn  in  MXBXNB  current BX number
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_bxn  out  MXBXNB  BX tag of head
out_clct0, out_clct1  out  22 each  {vld, pid, nhit, bend, subkey} (1+3+3+5+10)
out_edge  out  2  per-CLCT clamp flag of head
fifo_count  out  4  occupancy, 0..FIFO_DEPTH
ovf_cnt  out  16  saturating count of dropped pairs

Behaviour:
- Reset (global_reset_n=0 at clock edge): FIFO flushed, out_valid=0, out_clct*=0, out_bxn=0, out_edge=0, fifo_count=0, ovf_cnt=0, stage-1 register cleared. Reset mid-operation discards all buffered and in-flight pairs; no partial entry survives.
- Stage 1 (1 clock): capture inputs when lut_vld=1. A pair is formed only if vld0|vld1.
- Clamp:
  - Key field is subkey[9:2]. If key > MAXKEY, force subkey to {MAXKEY, 2'b11} and set edge bit.
  - The LUT wrap-under (key from 0 minus 2 reads as 0xFE/0xFF) is out of range, and is also > MAXKEY. For it, force subkey to 0 instead and set edge bit.
  - Discriminate wrap-under by key >= 8'hF0.
- Duplicate suppression: if vld0 & vld1 and post-clamp subkey1[9:2]==subkey0[9:2], clear vld1 and zero the clct1 word.
- If only vld1=1 (vld0=0), promote clct1 into the clct0 slot; clct1 slot is zero.
- Stage 2: push the entry {bxn captured at stage 1, clct0, clct1, edge} into the FIFO. Input-to-out_valid latency into an empty FIFO is 2 clocks.
- FIFO:
  - First-word-fall-through; head is presented on out_* while out_valid=1.
  - Pop occurs when out_valid & out_ready.
  - Push when not full, or when full with a pop in the same clock.
  - Push at full without a pop drops the new pair and increments ovf_cnt, which saturates at 16'hFFFF.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked by a separate counter, so full and empty are unambiguous.
  - Push and pop together at empty: the entry is not bypassed; it appears on the next clock.
  - out_ready while empty has no effect.
- out_* holds stable while out_valid=1 and out_ready=0.
- All arithmetic is unsigned. No signed interpretation of bend; bend is passed through unchanged.

Decomposition:
- Shared package cclut_pkg: MXKEYBX, MXXKYB, MXBNDB, MXPIDB, MXHITB, MAXKEY, CLCT word width (22) and field offsets, wrap-under threshold 8'hF0.
- One sub-module: cclut_pair_fifo, a generic FWFT FIFO with count and full/empty.
- Clamp, duplicate suppression and packing stay in the top level.

Test Plan:
- Single pair: vld0=1, subkey0=10'h1A5, pid0=4, nhit0=6, vld1=0, bxn=12'h123, out_ready=1 -> 2 clocks later out_valid=1 and out_clct0={1,3'd4,3'd6,bend0,10'h1A5}, out_clct1=0, out_bxn=12'h123. Next clock: out_valid=0.
- Clamp high and low: subkey0 key=8'hE5 (229) -> subkey0={8'd223,2'b11}, out_edge[0]=1. subkey1 key=8'hFE -> subkey1=0, out_edge[1]=1.
- Duplicate and promotion: subkey0=10'h0C8, subkey1=10'h0CA (same key 50) -> out_clct1=0. Separately, vld0=0, vld1=1, subkey1=10'h040 -> out_clct0 carries 10'h040 and out_clct1=0.
- Overflow: out_ready=0, 10 consecutive valid pairs -> fifo_count=8, ovf_cnt=2. Then out_ready=1 -> 8 pairs drain in push order with the correct bxn tags.
- Full with simultaneous push/pop: FIFO full, out_ready=1 and a new pair arrives -> fifo_count stays 8, ovf_cnt unchanged, new pair is last out.
- Reset mid-operation: 5 entries queued, global_reset_n=0 for 1 clock -> out_valid=0, fifo_count=0, ovf_cnt=0. A pair in stage 1 at reset never appears.

Source files
------------

// File: rtl/cclut_pkg.sv
// ---------------------------------------------------------------------------
// cclut_pkg
//
// Shared definitions for the CCLUT CLCT buffer:
//   - field widths of the LUT results (key, subkey, bend, pattern id, hits)
//   - highest legal half-strip key and the wrap-under threshold
//   - the packed CLCT word layout {vld, pid, nhit, bend, subkey}
//   - the subkey clamp helper used by the buffer top level
// ---------------------------------------------------------------------------
package cclut_pkg;

    localparam int MXKEYBX    = 8;    // half-strip key bits
    localparam int MXXKYB     = 10;   // subkey bits {key, QS, ES}
    localparam int MXBNDB     = 5;    // bend bits [4] L/R, [3:0] magnitude
    localparam int MXPIDB     = 3;    // pattern id bits
    localparam int MXHITB     = 3;    // hit-count bits
    localparam int MXBXNB     = 12;   // BX number bits
    localparam int FIFO_DEPTH = 8;    // pair entries, power of 2
    localparam int FIFO_CW    = $clog2(FIFO_DEPTH) + 1;

    // 7 CFEBs x 32 half-strips - 1
    localparam logic [MXKEYBX-1:0] MAXKEY   = 8'd223;

    // Keys at or above this came from the LUT subtracting below strip 0
    localparam logic [MXKEYBX-1:0] WRAP_KEY = 8'hF0;

    // CLCT word layout, LSB first: subkey, bend, nhit, pid, vld
    localparam int CLCT_W     = 1 + MXPIDB + MXHITB + MXBNDB + MXXKYB;
    localparam int SUBKEY_LSB = 0;
    localparam int BEND_LSB   = SUBKEY_LSB + MXXKYB;
    localparam int NHIT_LSB   = BEND_LSB + MXBNDB;
    localparam int PID_LSB    = NHIT_LSB + MXHITB;
    localparam int VLD_BIT    = PID_LSB + MXPIDB;

    // One FIFO entry: {bxn, clct0, clct1, edge flags}
    localparam int ENTRY_W    = MXBXNB + 2 * CLCT_W + 2;

    // Packed view of one CLCT word; member order matches the bit layout above
    typedef struct packed {
        logic              vld;
        logic [MXPIDB-1:0] pid;
        logic [MXHITB-1:0] nhit;
        logic [MXBNDB-1:0] bend;
        logic [MXXKYB-1:0] subkey;
    } clct_t;

    // Which way a key was pushed back into the legal range
    typedef enum logic [1:0] {
        CLAMP_NONE = 2'd0,
        CLAMP_HIGH = 2'd1,
        CLAMP_LOW  = 2'd2
    } clamp_kind_t;

    typedef struct packed {
        clamp_kind_t       kind;
        logic [MXXKYB-1:0] subkey;
    } clamp_t;

    // Keys past the last CFEB pin to the top corner {MAXKEY, QS=1, ES=1};
    // keys that wrapped below zero (0xF0 and up) pin to the bottom corner 0.
    // The wrap test must come first because wrapped keys also exceed MAXKEY.
    function automatic clamp_t clamp_subkey(input logic [MXXKYB-1:0] subkey);
        logic [MXKEYBX-1:0] key;
        clamp_t             result;
        key           = subkey[MXXKYB-1:MXXKYB-MXKEYBX];
        result.kind   = CLAMP_NONE;
        result.subkey = subkey;
        if (key >= WRAP_KEY) begin
            result.kind   = CLAMP_LOW;
            result.subkey = '0;
        end else if (key > MAXKEY) begin
            result.kind   = CLAMP_HIGH;
            result.subkey = {MAXKEY, 2'b11};
        end
        return result;
    endfunction

endpackage : cclut_pkg

// File: rtl/cclut_pair_fifo.sv
// ---------------------------------------------------------------------------
// cclut_pair_fifo
//
// Generic first-word-fall-through FIFO with an explicit occupancy counter.
// The head entry is visible on rd_data whenever rd_valid is high and is
// removed when rd_valid & rd_ready. A write while full is accepted only if
// the head is popped in the same clock; otherwise it is dropped and wr_drop
// pulses for that clock. Writes never bypass into an empty FIFO: a word
// written this clock becomes visible on the next.
//
// Ports:
//   clock     system clock
//   rst_n     synchronous active-low reset, empties the FIFO
//   wr_en     write request
//   wr_data   word to write
//   wr_drop   write request discarded because the FIFO was full
//   rd_ready  consumer takes the head this clock
//   rd_valid  head word present
//   rd_data   head word, zero while empty
//   count     occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module cclut_pair_fifo #(
    parameter int WIDTH = 58,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_drop,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0]  PTR_ONE = AW'(1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    occupancy;
    logic             full;
    logic             pop;
    logic             push;

    // Full/empty come from the counter, so equal pointers are never ambiguous
    assign full     = (occupancy == CNT_MAX);
    assign rd_valid = (occupancy != '0);
    assign pop      = rd_valid & rd_ready;
    assign push     = wr_en & (~full | pop);
    assign wr_drop  = wr_en & full & ~pop;
    assign count    = occupancy;

    // Head is masked while empty so stale storage never leaks onto the bus
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Storage needs no reset; only the pointers and count define its contents
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_ONE;
                2'b01:   occupancy <= occupancy - CNT_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule : cclut_pair_fifo

// File: rtl/cclut_clct_buffer.sv
// ---------------------------------------------------------------------------
// cclut_clct_buffer
//
// Takes the two CCLUT lookup results each BX, registers them, clamps
// out-of-range keys, suppresses a duplicate CLCT1, promotes a lone CLCT1
// into the CLCT0 slot, tags the pair with its BX number and queues it for
// the CLCT/ALCT matching logic. The queue drains under valid/ready.
//
// Ports:
//   clock            40 MHz system clock
//   global_reset_n   synchronous active-low reset
//   lut_vld          LUT outputs valid this clock
//   vld0, vld1       CLCT0 / CLCT1 present
//   subkey0/1        LUT best subkey {key, QS, ES}
//   bend0/1          LUT bend, passed through untouched
//   pid0/1           pattern id
//   nhit0/1          layers hit
//   bxn              current BX number
//   out_valid        queue head valid
//   out_ready        consumer accepts head
//   out_bxn          BX tag of head
//   out_clct0/1      {vld, pid, nhit, bend, subkey} of head
//   out_edge         per-CLCT clamp flag of head
//   fifo_count       queue occupancy
//   ovf_cnt          saturating count of dropped pairs
// ---------------------------------------------------------------------------
module cclut_clct_buffer
    import cclut_pkg::*;
(
    input  logic                clock,
    input  logic                global_reset_n,
    input  logic                lut_vld,
    input  logic                vld0,
    input  logic                vld1,
    input  logic [MXXKYB-1:0]   subkey0,
    input  logic [MXXKYB-1:0]   subkey1,
    input  logic [MXBNDB-1:0]   bend0,
    input  logic [MXBNDB-1:0]   bend1,
    input  logic [MXPIDB-1:0]   pid0,
    input  logic [MXPIDB-1:0]   pid1,
    input  logic [MXHITB-1:0]   nhit0,
    input  logic [MXHITB-1:0]   nhit1,
    input  logic [MXBXNB-1:0]   bxn,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MXBXNB-1:0]   out_bxn,
    output logic [CLCT_W-1:0]   out_clct0,
    output logic [CLCT_W-1:0]   out_clct1,
    output logic [1:0]          out_edge,
    output logic [FIFO_CW-1:0]  fifo_count,
    output logic [15:0]         ovf_cnt
);

    // Stage-1 registers
    logic                s1_pair;
    logic                s1_vld0;
    logic                s1_vld1;
    logic [MXXKYB-1:0]   s1_subkey0;
    logic [MXXKYB-1:0]   s1_subkey1;
    logic [MXBNDB-1:0]   s1_bend0;
    logic [MXBNDB-1:0]   s1_bend1;
    logic [MXPIDB-1:0]   s1_pid0;
    logic [MXPIDB-1:0]   s1_pid1;
    logic [MXHITB-1:0]   s1_nhit0;
    logic [MXHITB-1:0]   s1_nhit1;
    logic [MXBXNB-1:0]   s1_bxn;

    // Post-clamp, post-suppression pair
    clamp_t              clamp0;
    clamp_t              clamp1;
    logic                edge_hit0;
    logic                edge_hit1;
    logic                dup;
    clct_t               cand0;
    clct_t               cand1;
    clct_t               word0;
    clct_t               word1;
    logic [1:0]          edge_flags;
    logic [ENTRY_W-1:0]  entry;

    // FIFO side
    logic [ENTRY_W-1:0]  head;
    logic                fifo_drop;

    // Stage 1 captures the LUT results; a pair exists only if either CLCT is
    // present. Reset clears the stage so an in-flight pair cannot be pushed.
    always_ff @(posedge clock) begin
        if (!global_reset_n) begin
            s1_pair    <= 1'b0;
            s1_vld0    <= 1'b0;
            s1_vld1    <= 1'b0;
            s1_subkey0 <= '0;
            s1_subkey1 <= '0;
            s1_bend0   <= '0;
            s1_bend1   <= '0;
            s1_pid0    <= '0;
            s1_pid1    <= '0;
            s1_nhit0   <= '0;
            s1_nhit1   <= '0;
            s1_bxn     <= '0;
        end else begin
            s1_pair <= lut_vld & (vld0 | vld1);
            if (lut_vld) begin
                s1_vld0    <= vld0;
                s1_vld1    <= vld1;
                s1_subkey0 <= subkey0;
                s1_subkey1 <= subkey1;
                s1_bend0   <= bend0;
                s1_bend1   <= bend1;
                s1_pid0    <= pid0;
                s1_pid1    <= pid1;
                s1_nhit0   <= nhit0;
                s1_nhit1   <= nhit1;
                s1_bxn     <= bxn;
            end
        end
    end

    assign clamp0    = clamp_subkey(s1_subkey0);
    assign clamp1    = clamp_subkey(s1_subkey1);
    assign edge_hit0 = (clamp0.kind != CLAMP_NONE);
    assign edge_hit1 = (clamp1.kind != CLAMP_NONE);

    // Duplicate test uses the clamped keys, so two keys pinned to the same
    // corner also count as one CLCT
    assign dup = s1_vld0 & s1_vld1 &
                 (clamp0.subkey[MXXKYB-1:MXXKYB-MXKEYBX] ==
                  clamp1.subkey[MXXKYB-1:MXXKYB-MXKEYBX]);

    // Build both candidate words; an absent CLCT is an all-zero word
    always_comb begin
        cand0 = '0;
        cand1 = '0;
        if (s1_vld0) begin
            cand0.vld    = 1'b1;
            cand0.pid    = s1_pid0;
            cand0.nhit   = s1_nhit0;
            cand0.bend   = s1_bend0;
            cand0.subkey = clamp0.subkey;
        end
        if (s1_vld1) begin
            cand1.vld    = 1'b1;
            cand1.pid    = s1_pid1;
            cand1.nhit   = s1_nhit1;
            cand1.bend   = s1_bend1;
            cand1.subkey = clamp1.subkey;
        end
    end

    // Slot assignment: a lone CLCT1 moves into slot 0; a duplicate CLCT1 is
    // dropped. Edge flags follow their CLCT and vanish with it.
    always_comb begin
        word0      = '0;
        word1      = '0;
        edge_flags = 2'b00;
        if (s1_vld0) begin
            word0         = cand0;
            edge_flags[0] = edge_hit0;
            if (s1_vld1 && !dup) begin
                word1         = cand1;
                edge_flags[1] = edge_hit1;
            end
        end else if (s1_vld1) begin
            word0         = cand1;
            edge_flags[0] = edge_hit1;
        end
    end

    assign entry = {s1_bxn, word0, word1, edge_flags};

    cclut_pair_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pair_fifo (
        .clock    (clock),
        .rst_n    (global_reset_n),
        .wr_en    (s1_pair),
        .wr_data  (entry),
        .wr_drop  (fifo_drop),
        .rd_ready (out_ready),
        .rd_valid (out_valid),
        .rd_data  (head),
        .count    (fifo_count)
    );

    assign {out_bxn, out_clct0, out_clct1, out_edge} = head;

    // Dropped-pair counter sticks at all-ones rather than wrapping
    always_ff @(posedge clock) begin
        if (!global_reset_n) begin
            ovf_cnt <= '0;
        end else if (fifo_drop && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

endmodule : cclut_clct_buffer

// File: tb/tb_cclut_clct_buffer.sv
// ---------------------------------------------------------------------------
// tb_cclut_clct_buffer
//
// Directed bench for cclut_clct_buffer. Inputs change and outputs are
// sampled 1 time unit after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_cclut_clct_buffer;

    logic        clock;
    logic        global_reset_n;
    logic        lut_vld;
    logic        vld0;
    logic        vld1;
    logic [9:0]  subkey0;
    logic [9:0]  subkey1;
    logic [4:0]  bend0;
    logic [4:0]  bend1;
    logic [2:0]  pid0;
    logic [2:0]  pid1;
    logic [2:0]  nhit0;
    logic [2:0]  nhit1;
    logic [11:0] bxn;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_bxn;
    logic [21:0] out_clct0;
    logic [21:0] out_clct1;
    logic [1:0]  out_edge;
    logic [3:0]  fifo_count;
    logic [15:0] ovf_cnt;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_bxn  [8];
    logic [21:0] exp_word [8];

    cclut_clct_buffer dut (
        .clock          (clock),
        .global_reset_n (global_reset_n),
        .lut_vld        (lut_vld),
        .vld0           (vld0),
        .vld1           (vld1),
        .subkey0        (subkey0),
        .subkey1        (subkey1),
        .bend0          (bend0),
        .bend1          (bend1),
        .pid0           (pid0),
        .pid1           (pid1),
        .nhit0          (nhit0),
        .nhit1          (nhit1),
        .bxn            (bxn),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_bxn        (out_bxn),
        .out_clct0      (out_clct0),
        .out_clct1      (out_clct1),
        .out_edge       (out_edge),
        .fifo_count     (fifo_count),
        .ovf_cnt        (ovf_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net in case the sequence stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Hand-built valid CLCT word {vld, pid, nhit, bend, subkey}
    function automatic logic [21:0] mkWord(input logic [2:0] p, input logic [2:0] h,
                                           input logic [4:0] b, input logic [9:0] sk);
        return {1'b1, p, h, b, sk};
    endfunction

    // Present one LUT pair for exactly one clock, then idle the inputs
    task automatic applyStimulus(
        input logic v0, input logic [9:0] sk0, input logic [4:0] b0,
        input logic [2:0] p0, input logic [2:0] h0,
        input logic v1, input logic [9:0] sk1, input logic [4:0] b1,
        input logic [2:0] p1, input logic [2:0] h1,
        input logic [11:0] bx);
        lut_vld = 1'b1;
        vld0    = v0;  subkey0 = sk0; bend0 = b0; pid0 = p0; nhit0 = h0;
        vld1    = v1;  subkey1 = sk1; bend1 = b1; pid1 = p1; nhit1 = h1;
        bxn     = bx;
        tick();
        lut_vld = 1'b0;
        vld0    = 1'b0;
        vld1    = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        global_reset_n = 1'b0;
        lut_vld   = 1'b0;
        vld0      = 1'b0;  vld1    = 1'b0;
        subkey0   = '0;    subkey1 = '0;
        bend0     = '0;    bend1   = '0;
        pid0      = '0;    pid1    = '0;
        nhit0     = '0;    nhit1   = '0;
        bxn       = '0;
        out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_count", 64'(fifo_count), 64'd0);
        checkOutput("rst_ovf",   64'(ovf_cnt), 64'd0);
        checkOutput("rst_clct0", 64'(out_clct0), 64'd0);
        checkOutput("rst_clct1", 64'(out_clct1), 64'd0);
        checkOutput("rst_bxn",   64'(out_bxn), 64'd0);
        checkOutput("rst_edge",  64'(out_edge), 64'd0);
        global_reset_n = 1'b1;
        tick();

        // Single pair, two-clock latency, then popped
        applyStimulus(1'b1, 10'h1A5, 5'h13, 3'd4, 3'd6,
                      1'b0, 10'h000, 5'h00, 3'd0, 3'd0, 12'h123);
        checkOutput("single_lat1", 64'(out_valid), 64'd0);
        tick();
        checkOutput("single_valid", 64'(out_valid), 64'd1);
        checkOutput("single_clct0", 64'(out_clct0), 64'(mkWord(3'd4, 3'd6, 5'h13, 10'h1A5)));
        checkOutput("single_clct1", 64'(out_clct1), 64'd0);
        checkOutput("single_bxn",   64'(out_bxn), 64'h123);
        checkOutput("single_edge",  64'(out_edge), 64'd0);
        checkOutput("single_count", 64'(fifo_count), 64'd1);
        tick();
        checkOutput("single_popped", 64'(out_valid), 64'd0);
        checkOutput("single_empty",  64'(fifo_count), 64'd0);

        // Clamp high on CLCT0 (key 0xE5), wrap-under on CLCT1 (key 0xFE)
        applyStimulus(1'b1, 10'h395, 5'h04, 3'd1, 3'd5,
                      1'b1, 10'h3FA, 5'h1F, 3'd2, 3'd4, 12'h200);
        tick();
        checkOutput("clamp_valid", 64'(out_valid), 64'd1);
        checkOutput("clamp_clct0", 64'(out_clct0), 64'(mkWord(3'd1, 3'd5, 5'h04, 10'h37F)));
        checkOutput("clamp_clct1", 64'(out_clct1), 64'(mkWord(3'd2, 3'd4, 5'h1F, 10'h000)));
        checkOutput("clamp_edge",  64'(out_edge), 64'd3);
        checkOutput("clamp_bxn",   64'(out_bxn), 64'h200);
        tick();

        // Duplicate key 50 on both CLCTs: CLCT1 suppressed
        applyStimulus(1'b1, 10'h0C8, 5'h0A, 3'd3, 3'd6,
                      1'b1, 10'h0CA, 5'h15, 3'd1, 3'd4, 12'h300);
        tick();
        checkOutput("dup_clct0", 64'(out_clct0), 64'(mkWord(3'd3, 3'd6, 5'h0A, 10'h0C8)));
        checkOutput("dup_clct1", 64'(out_clct1), 64'd0);
        checkOutput("dup_edge",  64'(out_edge), 64'd0);
        tick();

        // Lone CLCT1 promoted; the junk CLCT0 inputs must be ignored
        applyStimulus(1'b0, 10'h3FC, 5'h07, 3'd1, 3'd1,
                      1'b1, 10'h040, 5'h11, 3'd2, 3'd3, 12'h301);
        tick();
        checkOutput("promo_clct0", 64'(out_clct0), 64'(mkWord(3'd2, 3'd3, 5'h11, 10'h040)));
        checkOutput("promo_clct1", 64'(out_clct1), 64'd0);
        checkOutput("promo_edge",  64'(out_edge), 64'd0);
        checkOutput("promo_bxn",   64'(out_bxn), 64'h301);
        tick();

        // Overflow: 10 back-to-back pairs with the consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] key;
            key = 8'd10 + 8'(i);
            applyStimulus(1'b1, {key, 2'b00}, 5'h00, 3'd2, 3'd3,
                          1'b0, 10'h000, 5'h00, 3'd0, 3'd0, 12'h400 + 12'(i));
        end
        tick();
        checkOutput("ovf_count", 64'(fifo_count), 64'd8);
        checkOutput("ovf_cnt",   64'(ovf_cnt), 64'd2);
        checkOutput("ovf_head",  64'(out_bxn), 64'h400);
        checkOutput("ovf_hold",  64'(out_clct0), 64'(mkWord(3'd2, 3'd3, 5'h00, 10'h028)));

        // New pair reaches the full FIFO in the same clock as the first pop
        applyStimulus(1'b1, 10'h2A0, 5'h00, 3'd2, 3'd3,
                      1'b0, 10'h000, 5'h00, 3'd0, 3'd0, 12'h4AA);
        out_ready = 1'b1;
        tick();
        checkOutput("pp_count", 64'(fifo_count), 64'd8);
        checkOutput("pp_ovf",   64'(ovf_cnt), 64'd2);

        // Drain: pairs 1..7 of the burst, then the late pair
        for (int k = 0; k < 7; k++) begin
            logic [7:0] key;
            key = 8'd11 + 8'(k);
            exp_bxn[k]  = 12'h401 + 12'(k);
            exp_word[k] = mkWord(3'd2, 3'd3, 5'h00, {key, 2'b00});
        end
        exp_bxn[7]  = 12'h4AA;
        exp_word[7] = mkWord(3'd2, 3'd3, 5'h00, 10'h2A0);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("drain_valid%0d", k), 64'(out_valid), 64'd1);
            checkOutput($sformatf("drain_bxn%0d", k), 64'(out_bxn), 64'(exp_bxn[k]));
            checkOutput($sformatf("drain_clct0_%0d", k), 64'(out_clct0), 64'(exp_word[k]));
            tick();
        end
        checkOutput("drain_empty", 64'(out_valid), 64'd0);
        checkOutput("drain_count", 64'(fifo_count), 64'd0);

        // Reset mid-operation: 5 queued plus one pair still in stage 1
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 10'h100, 5'h02, 3'd1, 3'd4,
                          1'b0, 10'h000, 5'h00, 3'd0, 3'd0, 12'h500 + 12'(i));
        end
        applyStimulus(1'b1, 10'h104, 5'h02, 3'd1, 3'd4,
                      1'b0, 10'h000, 5'h00, 3'd0, 3'd0, 12'h5FF);
        checkOutput("mid_count", 64'(fifo_count), 64'd5);
        global_reset_n = 1'b0;
        tick();
        checkOutput("mrst_valid", 64'(out_valid), 64'd0);
        checkOutput("mrst_count", 64'(fifo_count), 64'd0);
        checkOutput("mrst_ovf",   64'(ovf_cnt), 64'd0);
        global_reset_n = 1'b1;
        out_ready      = 1'b1;
        tick();
        tick();
        checkOutput("mrst_noghost_valid", 64'(out_valid), 64'd0);
        checkOutput("mrst_noghost_count", 64'(fifo_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cclut_clct_buffer
